// File: rtl/snitch_pkg.sv
// Shared types for the Snitch data request/response interface and the TCDM responder.
package snitch_pkg;

  localparam int unsigned IdWidth = 6;

  typedef enum logic [3:0] {
    AmoNone = 4'd0,
    AmoSwap = 4'd1,
    AmoAdd  = 4'd2,
    AmoAnd  = 4'd3,
    AmoOr   = 4'd4,
    AmoXor  = 4'd5,
    AmoMax  = 4'd6,
    AmoMaxu = 4'd7,
    AmoMin  = 4'd8,
    AmoMinu = 4'd9,
    AmoLR   = 4'd10,
    AmoSC   = 4'd11
  } amo_op_e;

  typedef struct packed {
    logic [31:0]        addr;
    logic [IdWidth-1:0] id;
    amo_op_e            amo;
    logic               write;
    logic [31:0]        data;
    logic [3:0]         strb;
  } dreq_t;

  typedef struct packed {
    logic [31:0]        data;
    logic [IdWidth-1:0] id;
    logic               write;
    logic               error;
  } dresp_t;

  typedef enum logic [0:0] {Idle, AmoWrite} resp_state_e;

  function automatic logic is_rmw(input amo_op_e op);
    return (op >= AmoSwap) && (op <= AmoMinu);
  endfunction

  // Codes 12..15 have no defined operation.
  function automatic logic is_unsupported(input amo_op_e op);
    return 4'(op) > 4'(AmoSC);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small circular FIFO with optional fall-through; synchronous active-high reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 2,
  parameter type         dtype        = logic,
  parameter int unsigned CntWidth     = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o,
  input  dtype                data_i,
  input  logic                push_i,
  output dtype                data_o,
  input  logic                pop_i
);
  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dtype                mem_q [DEPTH];
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                bypass, do_push, do_pop;

  function automatic logic [PtrWidth-1:0] incr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    bypass   = FALL_THROUGH && (cnt_q == '0) && push_i;
    full_o   = (cnt_q == CntWidth'(DEPTH));
    empty_o  = (cnt_q == '0) && !bypass;
    usage_o  = cnt_q;
    data_o   = bypass ? data_i : mem_q[rd_ptr_q];
    // A bypassed element consumed in the same cycle never touches storage.
    do_push  = push_i && !full_o && !(bypass && pop_i);
    do_pop   = pop_i && !empty_o && !bypass;
    wr_ptr_d = do_push ? incr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? incr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CntWidth'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snitch_tcdm_responder.sv
// TCDM bank responder: serves loads/stores, LR/SC and read-modify-write AMOs
// on one single-port SRAM and returns in-order responses tagged with the request id.
module snitch_tcdm_responder
  import snitch_pkg::*;
#(
  parameter int unsigned NumWords     = 1024,
  parameter int unsigned RespDepth    = 2,
  parameter int unsigned MemAddrWidth = $clog2(NumWords)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  dreq_t                   req_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output dresp_t                  resp_o,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_be_o,
  input  logic [31:0]             mem_rdata_i
);
  localparam int unsigned CntWidth = $clog2(RespDepth + 1);

  resp_state_e             state_q, state_d;
  dreq_t                   req_q, req_d;
  logic                    inflight_q, inflight_d;
  logic                    sc_ok_q, sc_ok_d;
  logic                    resv_valid_q, resv_valid_d;
  logic [MemAddrWidth-1:0] resv_addr_q, resv_addr_d;
  logic [MemAddrWidth-1:0] in_waddr, q_waddr;
  logic [CntWidth-1:0]     usage;
  logic [31:0]             amo_res;
  dresp_t                  resp_push;
  logic                    hs, sc_ok, push, q_full, q_empty, is_store;
  logic                    unused_bits;

  assign in_waddr = req_i.addr[MemAddrWidth+1:2];
  assign q_waddr  = req_q.addr[MemAddrWidth+1:2];
  assign sc_ok    = resv_valid_q && (resv_addr_q == in_waddr);
  assign is_store = (req_i.amo == AmoNone) && req_i.write;
  // Counting the in-flight request keeps the queue from ever overflowing.
  assign req_ready_o = !rst_i && (state_q == Idle) &&
                       ((32'(usage) + 32'(inflight_q)) < RespDepth);
  assign hs   = req_valid_i && req_ready_o;
  assign push = inflight_q && !rst_i;

  always_comb begin
    amo_res = mem_rdata_i;
    unique case (req_q.amo)
      AmoSwap: amo_res = req_q.data;
      AmoAdd:  amo_res = mem_rdata_i + req_q.data;
      AmoAnd:  amo_res = mem_rdata_i & req_q.data;
      AmoOr:   amo_res = mem_rdata_i | req_q.data;
      AmoXor:  amo_res = mem_rdata_i ^ req_q.data;
      AmoMax:  amo_res = ($signed(mem_rdata_i) > $signed(req_q.data)) ? mem_rdata_i : req_q.data;
      AmoMaxu: amo_res = (mem_rdata_i > req_q.data) ? mem_rdata_i : req_q.data;
      AmoMin:  amo_res = ($signed(mem_rdata_i) < $signed(req_q.data)) ? mem_rdata_i : req_q.data;
      AmoMinu: amo_res = (mem_rdata_i < req_q.data) ? mem_rdata_i : req_q.data;
      default: amo_res = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    inflight_d   = 1'b0;
    sc_ok_d      = sc_ok_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = in_waddr;
    mem_wdata_o  = req_i.data;
    mem_be_o     = 4'hF;
    unique case (state_q)
      Idle: begin
        if (hs) begin
          req_d      = req_i;
          inflight_d = 1'b1;
          sc_ok_d    = sc_ok;
          mem_req_o  = 1'b1;
          if (is_store) begin
            mem_we_o = 1'b1;
            mem_be_o = req_i.strb;
            if (in_waddr == resv_addr_q) resv_valid_d = 1'b0;
          end
          if (req_i.amo == AmoSC) begin
            mem_we_o     = sc_ok;
            resv_valid_d = 1'b0;
          end
          if (req_i.amo == AmoLR) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = in_waddr;
          end
          if (is_rmw(req_i.amo)) state_d = AmoWrite;
        end
      end
      AmoWrite: begin
        state_d     = Idle;
        mem_req_o   = !rst_i;
        mem_we_o    = !rst_i;
        mem_addr_o  = q_waddr;
        mem_wdata_o = amo_res;
        if (q_waddr == resv_addr_q) resv_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    resp_push      = '0;
    resp_push.id   = req_q.id;
    resp_push.data = mem_rdata_i;
    if ((req_q.amo == AmoNone) && req_q.write) begin
      resp_push.write = 1'b1;
      resp_push.data  = '0;
    end else if (req_q.amo == AmoSC) begin
      resp_push.data = {31'd0, ~sc_ok_q};
    end else if (is_unsupported(req_q.amo)) begin
      resp_push.error = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      req_q        <= '0;
      inflight_q   <= 1'b0;
      sc_ok_q      <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      inflight_q   <= inflight_d;
      sc_ok_q      <= sc_ok_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH(1'b1),
    .DEPTH       (RespDepth),
    .dtype       (dresp_t)
  ) i_resp_queue (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(1'b0),
    .full_o (q_full),
    .empty_o(q_empty),
    .usage_o(usage),
    .data_i (resp_push),
    .push_i (push),
    .data_o (resp_o),
    .pop_i  (resp_ready_i)
  );

  assign resp_valid_o = !q_empty;

  assign unused_bits = ^{req_i.addr[31:MemAddrWidth+2], req_i.addr[1:0],
                         req_q.addr[31:MemAddrWidth+2], req_q.addr[1:0], req_q.strb, q_full};

endmodule
